tmds_gearbox: RTL and testbench
===============================

# tmds_gearbox

Parametrised, vendor-neutral TMDS output gearbox for the HDMI path. It runs entirely in the fast serial clock domain and accepts 10-bit TMDS symbols per channel through a valid/ready handshake. It emits OUT_W bits per channel per clock, generates the TMDS clock lane as a pattern lane, applies per-channel polarity inversion, and substitutes idle or test symbols on underflow or on request. It sits between the TMDS encoders and the pad primitives (DDR or plain output registers) on targets without a hard 10:1 serializer.

## Interface
- NUM_CHANNELS, 3, data lanes.
- WORD_W, 10, symbol width.
- OUT_W, 2, bits per lane per clock; must divide WORD_W (1, 2, 5, 10). B = WORD_W/OUT_W beats per symbol.
- POL_INV, '0, NUM_CHANNELS+1 bit vector: bit i inverts data lane i; bit NUM_CHANNELS inverts the clock lane.
- LSB_FIRST, 1, 1 = bit 0 of the symbol leaves first.
- IDLE_SYM, 10'b1101010100, control symbol (C1=C0=0) inserted on underflow.

Ports:
- clk_pixel_x5  in  1  serial-rate clock (pixel rate × B).
- reset  in  1  synchronous, active-high.
- in_valid  in  1  symbol set on tmds_internal is valid.
- in_ready  out  1  gearbox accepts this cycle.
- tmds_internal  in  [NUM_CHANNELS-1:0][WORD_W-1:0]  symbols, one per lane.
- pattern_en  in  1  replace data with pattern_sym at each load.
- pattern_sym  in  WORD_W  test symbol.
- underflow_clear  in  1  clears the sticky flag.
- tmds_out  out  [NUM_CHANNELS-1:0][OUT_W-1:0]  lane bits, earliest bit in bit 0.
- tmds_clock_out  out  OUT_W  clock-lane bits.
- word_start  out  1  high on the beat-0 cycle of each symbol.
- underflow  out  1  sticky: an idle symbol was inserted.

## Operation
- Per-lane state: a shift register sh[WORD_W]. Shared state: beat counter (0..B-1), hold register hold[lanes] with hold_valid, and FSM {PRIME, RUN}.
- Each cycle every lane outputs OUT_W bits of sh and shifts by OUT_W. Bit order is set by LSB_FIRST.
- The load edge is the edge where beat == B-1. At that edge:
  - if hold_valid: sh ← hold, and hold is refilled if in_valid.
  - else if in_valid: sh ← tmds_internal (bypass).
  - else: sh ← IDLE_SYM on all lanes. In RUN this sets underflow.
- in_ready = !reset && (!hold_valid || beat == B-1).
- A transfer (in_valid && in_ready) on a non-load edge writes hold.
- pattern_en is sampled at the load edge. If set, sh ← pattern_sym on all lanes. The data handshake still proceeds and the data is discarded, so upstream never stalls.
- The clock lane emits the fixed pattern 1111100000 (first five bits transmitted are 1), aligned to the beat counter.
- FSM: reset → PRIME. PRIME → RUN on the first accepted transfer. In PRIME, idle insertions do not set underflow.
- Polarity inversion (XOR with POL_INV) is applied at the output register only.
- underflow_clear and a new underflow on the same edge: set wins.

## Timing
- All outputs are registered.
- During reset and on the first cycle after it:
  - tmds_out = the bits of IDLE_SYM for beat 0, XOR POL_INV.
  - tmds_clock_out = clock-pattern beat 0 XOR POL_INV.
  - beat = 0, word_start = 1, hold_valid = 0, underflow = 0, in_ready = 0, FSM = PRIME.
- Throughput: one symbol set per B cycles, sustained with no bubbles when in_valid is held.
- Latency:
  - Bypass: a symbol accepted at the load edge appears as beat 0 on the next cycle.
  - Held: a symbol accepted at any other edge appears at the next load edge, which is at most B cycles away.
- Back-pressure: when hold is full, in_ready is low except on the load cycle. A stalled in_valid must hold its data stable.
- Reset mid-symbol aborts the symbol and discards hold. The output restarts at beat 0 of IDLE_SYM on the next cycle.
- OUT_W = WORD_W (B = 1): every edge is a load edge and hold is never used.

## Structure
- tmds_pkg: IDLE_SYM and the other TMDS control symbols, the clock-lane pattern constant, and a function that reverses bits for LSB_FIRST = 0.
- Sub-module tmds_lane_shifter (one per lane plus one for the clock lane): sh register, load, shift, and output inversion. The top level owns the beat counter, hold register, FSM and handshake.

## Test plan
- Reset release with no in_valid for 20 cycles (OUT_W = 2) → IDLE_SYM streams on every lane; the clock lane reads 11,11,10,00,00 per symbol; underflow stays 0.
- Continuous in_valid, lane 0 values 0x2AB, 0x154, … → the lane 0 bitstream matches LSB-first order, 5 cycles per symbol, with no idle insertion.
- in_valid dropped for one symbol time after RUN → IDLE_SYM is inserted, underflow = 1. underflow_clear resets it; if clear coincides with a new underflow, underflow stays 1.
- Hold full, in_valid held for 3 symbols → in_ready is high only on the beat-4 cycles; no symbol is lost or duplicated.
- POL_INV = 4'b1010 → lane 1 and the clock lane are bit-inverted; lanes 0 and 2 are unchanged.
- pattern_en = 1 with pattern_sym = 0x3FF, then reset asserted at beat 2 → all lanes are 1s from the next load. After reset the output restarts at IDLE_SYM beat 0 and the FSM is in PRIME.

Source files
------------

// File: rtl/tmds_gearbox_pkg.sv
// Shared definitions for the TMDS output gearbox.
// Contents: TMDS control symbols, the clock-lane pattern, the gearbox FSM
// state type and a bit-reversal helper used when symbols leave MSB first.
package tmds_gearbox_pkg;

  localparam int unsigned TMDS_W = 10;

  // Control symbols indexed by {C1, C0}.
  localparam logic [TMDS_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

  // Clock lane in transmission order: bit 0 leaves first, so five 1s then five 0s.
  localparam logic [TMDS_W-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

  typedef enum logic [0:0] {StPrime, StRun} gb_state_e;

  function automatic logic [TMDS_W-1:0] reverse_bits(input logic [TMDS_W-1:0] w);
    logic [TMDS_W-1:0] r;
    for (int i = 0; i < TMDS_W; i++) begin
      r[i] = w[TMDS_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/tmds_gearbox_if.sv
// Symbol handshake between the TMDS encoders (master) and the gearbox (slave).
//   in_valid      : master -> slave, symbol set on tmds_internal is valid
//   in_ready      : slave -> master, gearbox accepts this cycle
//   tmds_internal : master -> slave, one WORD_W symbol per data lane
interface tmds_gearbox_if #(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned WORD_W       = 10
) ();

  logic                                 in_valid;
  logic                                 in_ready;
  logic [NUM_CHANNELS-1:0][WORD_W-1:0]  tmds_internal;

  modport master (output in_valid, output tmds_internal, input in_ready);
  modport slave  (input in_valid, input tmds_internal, output in_ready);

endinterface

// File: rtl/tmds_gearbox_lane_shifter.sv
// One output lane of the TMDS gearbox: holds the not-yet-sent bits of the
// current symbol and emits OUT_W bits per clock, earliest bit in bits[0].
//   clk       : serial-rate clock
//   reset     : synchronous, active-high; restarts at beat 0 of RESET_WORD
//   load      : take load_word this edge instead of shifting
//   load_word : next symbol, already in transmission order (bit 0 first)
//   bits      : registered lane output, polarity inversion applied
module tmds_gearbox_lane_shifter #(
  parameter int unsigned      WORD_W     = 10,
  parameter int unsigned      OUT_W      = 2,
  parameter logic [WORD_W-1:0] RESET_WORD = '0,
  parameter bit               INV        = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  output logic [OUT_W-1:0]  bits
);

  localparam logic [OUT_W-1:0] InvMask = {OUT_W{INV}};

  // sh_q holds the bits still to be sent; bits_q is the beat on the wire now.
  logic [WORD_W-1:0] sh_q;
  logic [OUT_W-1:0]  bits_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= RESET_WORD >> OUT_W;
      bits_q <= RESET_WORD[OUT_W-1:0] ^ InvMask;
    end else if (load) begin
      sh_q   <= load_word >> OUT_W;
      bits_q <= load_word[OUT_W-1:0] ^ InvMask;
    end else begin
      sh_q   <= sh_q >> OUT_W;
      bits_q <= sh_q[OUT_W-1:0] ^ InvMask;
    end
  end

  assign bits = bits_q;

endmodule

// File: rtl/tmds_gearbox.sv
// TMDS output gearbox: turns one WORD_W symbol per lane every B clocks into
// OUT_W bits per lane per clock, plus a generated clock lane.
//   clk_pixel_x5    : serial-rate clock (pixel rate x B)
//   reset           : synchronous, active-high
//   up              : symbol handshake (slave side)
//   pattern_en      : replace data with pattern_sym at each load
//   pattern_sym     : test symbol
//   underflow_clear : clears the sticky underflow flag
//   tmds_out        : per-lane bits, earliest bit in bit 0
//   tmds_clock_out  : clock-lane bits
//   word_start      : high on the beat-0 cycle of each symbol
//   underflow       : sticky, an idle symbol was inserted while running
module tmds_gearbox
  import tmds_gearbox_pkg::*;
#(
  parameter int unsigned             NUM_CHANNELS = 3,
  parameter int unsigned             WORD_W       = 10,
  parameter int unsigned             OUT_W        = 2,
  parameter logic [NUM_CHANNELS:0]   POL_INV      = '0,
  parameter bit                      LSB_FIRST    = 1'b1,
  parameter logic [WORD_W-1:0]       IDLE_SYM     = TMDS_CTRL_00
) (
  input  logic                                clk_pixel_x5,
  input  logic                                reset,
  tmds_gearbox_if.slave                       up,
  input  logic                                pattern_en,
  input  logic [WORD_W-1:0]                   pattern_sym,
  input  logic                                underflow_clear,
  output logic [NUM_CHANNELS-1:0][OUT_W-1:0]  tmds_out,
  output logic [OUT_W-1:0]                    tmds_clock_out,
  output logic                                word_start,
  output logic                                underflow
);

  localparam int unsigned      B        = WORD_W / OUT_W;
  localparam int unsigned      BeatW    = (B > 1) ? $clog2(B) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(B - 1);

  function automatic logic [WORD_W-1:0] order_bits(input logic [WORD_W-1:0] w);
    return LSB_FIRST ? w : reverse_bits(w);
  endfunction

  localparam logic [WORD_W-1:0] IdleOrdered = LSB_FIRST ? IDLE_SYM : reverse_bits(IDLE_SYM);

  logic [BeatW-1:0]                    beat_q;
  logic [NUM_CHANNELS-1:0][WORD_W-1:0] hold_q;
  logic                                hold_valid_q;
  logic                                word_start_q;
  logic                                underflow_q;
  gb_state_e                           state_q;

  logic                                load;
  logic                                accept;
  logic                                idle_insert;
  logic [NUM_CHANNELS-1:0][WORD_W-1:0] load_words;

  assign load        = (beat_q == LastBeat);
  assign up.in_ready = !reset && (!hold_valid_q || load);
  assign accept      = up.in_valid && up.in_ready;
  // Pattern mode replaces the symbol, so nothing idle reaches the wire then.
  assign idle_insert = load && !hold_valid_q && !up.in_valid && !pattern_en;

  always_comb begin
    load_words = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (pattern_en)        load_words[i] = order_bits(pattern_sym);
      else if (hold_valid_q) load_words[i] = order_bits(hold_q[i]);
      else if (up.in_valid)  load_words[i] = order_bits(up.tmds_internal[i]);
      else                   load_words[i] = IdleOrdered;
    end
  end

  always_ff @(posedge clk_pixel_x5) begin
    if (reset) begin
      beat_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      word_start_q <= 1'b1;
      underflow_q  <= 1'b0;
      state_q      <= StPrime;
    end else begin
      beat_q       <= load ? '0 : beat_q + 1'b1;
      word_start_q <= load;
      if (load) begin
        // Hold drains into the shifters; a concurrent transfer refills it.
        hold_valid_q <= hold_valid_q && up.in_valid;
        if (hold_valid_q && up.in_valid) hold_q <= up.tmds_internal;
      end else if (accept) begin
        hold_valid_q <= 1'b1;
        hold_q       <= up.tmds_internal;
      end
      if (accept) state_q <= StRun;
      // A new underflow beats a simultaneous clear.
      if (idle_insert && state_q == StRun) underflow_q <= 1'b1;
      else if (underflow_clear)            underflow_q <= 1'b0;
    end
  end

  assign word_start = word_start_q;
  assign underflow  = underflow_q;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
    tmds_gearbox_lane_shifter #(
      .WORD_W     (WORD_W),
      .OUT_W      (OUT_W),
      .RESET_WORD (IdleOrdered),
      .INV        (POL_INV[i])
    ) u_lane (
      .clk       (clk_pixel_x5),
      .reset     (reset),
      .load      (load),
      .load_word (load_words[i]),
      .bits      (tmds_out[i])
    );
  end

  tmds_gearbox_lane_shifter #(
    .WORD_W     (WORD_W),
    .OUT_W      (OUT_W),
    .RESET_WORD (TMDS_CLK_PATTERN),
    .INV        (POL_INV[NUM_CHANNELS])
  ) u_clock_lane (
    .clk       (clk_pixel_x5),
    .reset     (reset),
    .load      (load),
    .load_word (TMDS_CLK_PATTERN),
    .bits      (tmds_clock_out)
  );

endmodule

// File: tb/tb_tmds_gearbox.sv
// Directed bench for tmds_gearbox (OUT_W = 2). A second instance with
// POL_INV = 4'b1010 sees the same stimulus and is checked against the
// inverted expected stream.
module tb_tmds_gearbox;

  localparam int unsigned NCH = 3;
  localparam int unsigned WW  = 10;
  localparam int unsigned OW  = 2;
  localparam int          NB  = 5;

  typedef logic [NCH-1:0][WW-1:0] sym_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          pat_en;
  logic [WW-1:0] pat_sym;
  logic          uf_clr;

  logic [NCH-1:0][OW-1:0] out_a, out_b;
  logic [OW-1:0]          clk_a, clk_b;
  logic                   ws_a, ws_b, uf_a, uf_b;

  tmds_gearbox_if #(.NUM_CHANNELS(NCH), .WORD_W(WW)) ifa ();
  tmds_gearbox_if #(.NUM_CHANNELS(NCH), .WORD_W(WW)) ifb ();

  assign ifb.in_valid      = ifa.in_valid;
  assign ifb.tmds_internal = ifa.tmds_internal;

  tmds_gearbox #(.NUM_CHANNELS(NCH), .WORD_W(WW), .OUT_W(OW)) dut_a (
    .clk_pixel_x5    (clk),
    .reset           (rst),
    .up              (ifa),
    .pattern_en      (pat_en),
    .pattern_sym     (pat_sym),
    .underflow_clear (uf_clr),
    .tmds_out        (out_a),
    .tmds_clock_out  (clk_a),
    .word_start      (ws_a),
    .underflow       (uf_a)
  );

  tmds_gearbox #(.NUM_CHANNELS(NCH), .WORD_W(WW), .OUT_W(OW), .POL_INV(4'b1010)) dut_b (
    .clk_pixel_x5    (clk),
    .reset           (rst),
    .up              (ifb),
    .pattern_en      (pat_en),
    .pattern_sym     (pat_sym),
    .underflow_clear (uf_clr),
    .tmds_out        (out_b),
    .tmds_clock_out  (clk_b),
    .word_start      (ws_b),
    .underflow       (uf_b)
  );

  logic [WW-1:0] idle_w = 10'b1101010100;
  logic [WW-1:0] clk_pat = 10'b0000011111;   // transmission order, bit 0 first
  logic [NCH:0]  inv_b = 4'b1010;
  logic [WW-1:0] vals [8];

  int   n_assert = 0;
  int   n_fail = 0;
  int   beat = 0;       // beat currently on the wire
  int   k = 0;
  logic chk_bp = 1'b0;
  logic last_acc;
  sym_t exp_sym;
  sym_t sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic sym_t mk_sym(input logic [WW-1:0] v);
    sym_t s;
    s[0] = v;
    s[1] = v ^ 10'h0F0;
    s[2] = {v[4:0], v[9:5]};
    return s;
  endfunction

  // One clock: note any transfer, advance the model, check every output.
  task automatic cycle();
    logic          was_rst, was_pat;
    logic [WW-1:0] was_psym;
    sym_t          item;
    #1;
    was_rst  = rst;
    was_pat  = pat_en;
    was_psym = pat_sym;
    last_acc = ifa.in_valid && ifa.in_ready;
    if (rst) chk("in_ready_in_reset", 32'(ifa.in_ready), 0);
    if (chk_bp) chk("in_ready_backpressure", 32'(ifa.in_ready), 32'(beat == NB - 1));
    if (last_acc) sb.push_back(ifa.tmds_internal);
    @(negedge clk);
    if (was_rst) begin
      beat = 0;
      sb.delete();
      exp_sym = {NCH{idle_w}};
    end else begin
      beat = (beat + 1) % NB;
      if (beat == 0) begin
        if (sb.size() > 0) item = sb.pop_front();
        else item = {NCH{idle_w}};
        exp_sym = was_pat ? {NCH{was_psym}} : item;
      end
    end
    chk("word_start", 32'(ws_a), 32'(beat == 0));
    chk("word_start_inv", 32'(ws_b), 32'(beat == 0));
    for (int l = 0; l < NCH; l++) begin
      chk($sformatf("lane%0d", l), 32'(out_a[l]), 32'(exp_sym[l][beat*OW +: OW]));
      chk($sformatf("lane%0d_inv", l), 32'(out_b[l]),
          32'(exp_sym[l][beat*OW +: OW] ^ {OW{inv_b[l]}}));
    end
    chk("clock_lane", 32'(clk_a), 32'(clk_pat[beat*OW +: OW]));
    chk("clock_lane_inv", 32'(clk_b), 32'(clk_pat[beat*OW +: OW] ^ {OW{inv_b[NCH]}}));
  endtask

  task automatic wait_beat(input int b);
    int n = 0;
    while (beat != b && n < 10) begin
      cycle();
      n++;
    end
    chk("wait_beat_bound", 32'(beat), 32'(b));
  endtask

  initial begin
    vals[0] = 10'h2AB; vals[1] = 10'h154; vals[2] = 10'h0F3; vals[3] = 10'h30C;
    vals[4] = 10'h1E1; vals[5] = 10'h21E; vals[6] = 10'h3C0; vals[7] = 10'h03F;
    rst = 1'b1;
    pat_en = 1'b0;
    pat_sym = '0;
    uf_clr = 1'b0;
    ifa.in_valid = 1'b0;
    ifa.tmds_internal = '0;
    exp_sym = {NCH{idle_w}};

    // Reset, then 20 idle cycles while priming.
    repeat (3) cycle();
    chk("underflow_reset", 32'(uf_a), 0);
    rst = 1'b0;
    repeat (20) cycle();
    chk("underflow_prime_idle", 32'(uf_a), 0);

    // Continuous stream; once hold is full, in_ready only on beat 4.
    ifa.in_valid = 1'b1;
    ifa.tmds_internal = mk_sym(vals[0]);
    for (int c = 0; c < 30; c++) begin
      if (c == 10) chk_bp = 1'b1;
      cycle();
      if (last_acc) begin
        k++;
        ifa.tmds_internal = mk_sym(vals[k % 8]);
      end
    end
    chk_bp = 1'b0;
    chk("underflow_streaming", 32'(uf_a), 0);

    // Starve the gearbox: hold drains, then idle is inserted.
    ifa.in_valid = 1'b0;
    repeat (12) cycle();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    chk("underflow_set", 32'(uf_a), 1);
    chk("underflow_set_inv", 32'(uf_b), 1);

    // Clear on a non-load edge, then clear coinciding with a new underflow.
    wait_beat(1);
    uf_clr = 1'b1;
    cycle();
    uf_clr = 1'b0;
    chk("underflow_cleared", 32'(uf_a), 0);
    wait_beat(4);
    uf_clr = 1'b1;
    cycle();
    uf_clr = 1'b0;
    chk("underflow_set_wins", 32'(uf_a), 1);

    // Pattern mode with data still flowing, then reset mid-symbol.
    pat_sym = 10'h3FF;
    pat_en = 1'b1;
    ifa.in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (last_acc) begin
        k++;
        ifa.tmds_internal = mk_sym(vals[k % 8]);
      end
    end
    wait_beat(2);
    rst = 1'b1;
    cycle();
    chk("word_start_after_reset", 32'(ws_a), 1);
    chk("underflow_after_reset", 32'(uf_a), 0);
    rst = 1'b0;
    pat_en = 1'b0;
    ifa.in_valid = 1'b0;
    repeat (15) cycle();
    chk("underflow_prime_after_reset", 32'(uf_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
